mux81_rr_sched: RTL

Round-robin scheduler that shares the 8:1 bit multiplexer between eight requesters. Each requester i owns input bit `in_word[i]`. The block grants the mux to one requester at a time for a bounded dwell period, drives `sel`, and presents the selected bit as a registered output stream with a valid flag. It sits directly in front of the mux81 datapath and replaces free-running `sel` stimulus with fair, request-driven sequencing.

---
 rtl/mux81_rr_sched_if.sv | 20 ++
 rtl/mux81_rr_sched.sv | 113 +++++++++++
 2 files changed

// File: rtl/mux81_rr_sched_if.sv
// rtl/mux81_rr_sched_if.sv - request/data/grant bundle between requesters and the mux81 round-robin scheduler
interface mux81_rr_sched_if;
    logic [7:0] req;
    logic [7:0] in_word;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       out_bit;
    logic       out_valid;

    modport master (
        output req, in_word,
        input  grant, sel, busy, out_bit, out_valid
    );

    modport slave (
        input  req, in_word,
        output grant, sel, busy, out_bit, out_valid
    );
endinterface

// File: rtl/mux81_rr_sched.sv
// rtl/mux81_rr_sched.sv - round-robin, dwell-bounded scheduler driving the 8:1 bit mux select
module mux81_rr_sched #(
    parameter int DWELL = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    mux81_rr_sched_if.slave        bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] g_q, g_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] sel_q, sel_d;
    logic       busy_q;
    logic       out_bit_q;
    logic       out_valid_q;
    logic [3:0] pick_idle;
    logic [3:0] pick_next;
    logic       grant_end;

    // Returns {found, index} of the first requester at or after p, wrapping mod 8.
    function automatic logic [3:0] arb(input logic [2:0] p, input logic [7:0] r);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            idx = p + 3'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        g_d       = g_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        pick_idle = arb(ptr_q, bus.req);
        pick_next = arb(g_q + 3'd1, bus.req);
        grant_end = !bus.req[g_q] || (cnt_q == DWELL_LAST);

        case (state_q)
            IDLE: begin
                grant_d = 8'd0;
                if (pick_idle[3]) begin
                    g_d     = pick_idle[2:0];
                    grant_d = 8'd1 << pick_idle[2:0];
                    sel_d   = pick_idle[2:0];
                    cnt_d   = 8'd0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (grant_end) begin
                    // Re-arbitrate from the advanced pointer so handover has no idle gap.
                    ptr_d = g_q + 3'd1;
                    cnt_d = 8'd0;
                    if (pick_next[3]) begin
                        g_d     = pick_next[2:0];
                        grant_d = 8'd1 << pick_next[2:0];
                        sel_d   = pick_next[2:0];
                    end else begin
                        grant_d = 8'd0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                grant_d = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            cnt_q       <= 8'd0;
            g_q         <= 3'd0;
            grant_q     <= 8'd0;
            sel_q       <= 3'd0;
            busy_q      <= 1'b0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            g_q         <= g_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            busy_q      <= (grant_d != 8'd0);
            out_bit_q   <= bus.in_word[sel_q];
            out_valid_q <= busy_q;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = busy_q;
    assign bus.out_bit   = out_bit_q;
    assign bus.out_valid = out_valid_q;
endmodule
